// File: rtl/mul16_pkg.sv
// Shared types and widths for the sequential 16x16 multiplier arbiter.
package mul16_pkg;

    localparam int unsigned PROD_W = 32;
    localparam int unsigned HALF_W = 8;
    localparam int unsigned OP_W   = 2 * HALF_W;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        P0   = 3'd1,
        P1   = 3'd2,
        P2   = 3'd3,
        P3   = 3'd4,
        DONE = 3'd5
    } state_t;

endpackage

// File: rtl/mul16_seq_arbiter_rr_arb.sv
// Combinational round-robin arbiter: one-hot grant, searching from ptr upward with wrap.
module rr_arb #(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned PTR_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  grant_c
);

    logic             found;
    logic [PTR_W-1:0] idx;

    always_comb begin
        grant_c = '0;
        found   = 1'b0;
        idx     = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = PTR_W'((32'(ptr) + k) % NREQ);
            if (!found && req[idx]) begin
                grant_c[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mul16_seq_arbiter.sv
// Shares one external 8x8 multiplier among NREQ requesters; each 16x16 product is
// built from four partial products accumulated in a 32-bit register.
module mul16_seq_arbiter
    import mul16_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned ID_W = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*OP_W-1:0] req_a,
    input  logic [NREQ*OP_W-1:0] req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [PROD_W-1:0]    rsp_data,
    output logic [ID_W-1:0]      rsp_id,
    output logic                 busy,
    output logic [HALF_W-1:0]    mul_x,
    output logic [HALF_W-1:0]    mul_y,
    input  logic [OP_W-1:0]      mul_p
);

    state_t              state, state_nxt;
    logic [NREQ-1:0]     grant_c;
    logic [ID_W-1:0]     ptr;
    logic [ID_W-1:0]     gidx_c;
    logic [OP_W-1:0]     a_sel_c, b_sel_c;
    logic [OP_W-1:0]     op_a, op_b;
    logic [ID_W-1:0]     id_q;
    logic [PROD_W-1:0]   acc;
    logic [PROD_W-1:0]   addend_c;
    logic [PROD_W-1:0]   acc_sum_c;
    logic                accept_c;

    rr_arb #(.NREQ(NREQ), .PTR_W(ID_W)) u_arb (
        .req     (req_valid),
        .ptr     (ptr),
        .grant_c (grant_c)
    );

    // Winner index and its operands, selected from the one-hot grant
    always_comb begin
        gidx_c  = '0;
        a_sel_c = '0;
        b_sel_c = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant_c[i]) begin
                gidx_c  = ID_W'(i);
                a_sel_c = req_a[i*OP_W +: OP_W];
                b_sel_c = req_b[i*OP_W +: OP_W];
            end
        end
    end

    assign accept_c  = (state == IDLE) && (|grant_c);
    assign acc_sum_c = acc + addend_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|grant_c) state_nxt = P0;
            P0:      state_nxt = P1;
            P1:      state_nxt = P2;
            P2:      state_nxt = P3;
            P3:      state_nxt = DONE;
            DONE:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Half-select mux feeding the shared core, plus the aligned partial product
    always_comb begin
        req_ready = '0;
        mul_x     = '0;
        mul_y     = '0;
        addend_c  = '0;
        case (state)
            IDLE: req_ready = grant_c;
            P0: begin
                mul_x    = op_a[HALF_W-1:0];
                mul_y    = op_b[HALF_W-1:0];
                addend_c = PROD_W'(mul_p);
            end
            P1: begin
                mul_x    = op_a[OP_W-1:HALF_W];
                mul_y    = op_b[HALF_W-1:0];
                addend_c = PROD_W'(mul_p) << HALF_W;
            end
            P2: begin
                mul_x    = op_a[HALF_W-1:0];
                mul_y    = op_b[OP_W-1:HALF_W];
                addend_c = PROD_W'(mul_p) << HALF_W;
            end
            P3: begin
                mul_x    = op_a[OP_W-1:HALF_W];
                mul_y    = op_b[OP_W-1:HALF_W];
                addend_c = PROD_W'(mul_p) << OP_W;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a      <= '0;
            op_b      <= '0;
            id_q      <= '0;
            ptr       <= '0;
            acc       <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            busy      <= 1'b0;
        end else begin
            busy <= (state_nxt != IDLE);
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        op_a <= a_sel_c;
                        op_b <= b_sel_c;
                        id_q <= gidx_c;
                        acc  <= '0;
                        ptr  <= ID_W'((32'(gidx_c) + 32'd1) % NREQ);
                    end
                end
                P0, P1, P2: acc <= acc_sum_c;
                P3: begin
                    acc       <= acc_sum_c;
                    rsp_data  <= acc_sum_c;
                    rsp_id    <= id_q;
                    rsp_valid <= 1'b1;
                end
                DONE: if (rsp_ready) rsp_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul16_seq_arbiter.sv
// Self-checking bench: directed cases on NREQ=2, randomized traffic on NREQ=2 and NREQ=3.
module tb_mul16_seq_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic [2:0]  v;
    logic [47:0] ra, rb;
    logic        rrdy;

    logic [1:0]  ready2;
    logic        rv2, busy2;
    logic [31:0] rd2;
    logic [0:0]  rid2;
    logic [7:0]  mx2, my2;
    logic [15:0] mp2;

    logic [2:0]  ready3;
    logic        rv3, busy3;
    logic [31:0] rd3;
    logic [1:0]  rid3;
    logic [7:0]  mx3, my3;
    logic [15:0] mp3;

    logic [2:0]  o_ready;
    logic        o_rv, o_busy;
    logic [31:0] o_rd;
    logic [1:0]  o_id;
    logic [7:0]  o_mx, o_my;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign mp2 = 16'(mx2) * 16'(my2);
    assign mp3 = 16'(mx3) * 16'(my3);

    mul16_seq_arbiter #(.NREQ(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(sel ? 2'b00 : v[1:0]), .req_ready(ready2),
        .req_a(ra[31:0]), .req_b(rb[31:0]),
        .rsp_valid(rv2), .rsp_ready(rrdy), .rsp_data(rd2), .rsp_id(rid2),
        .busy(busy2), .mul_x(mx2), .mul_y(my2), .mul_p(mp2)
    );

    mul16_seq_arbiter #(.NREQ(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(sel ? v : 3'b000), .req_ready(ready3),
        .req_a(ra), .req_b(rb),
        .rsp_valid(rv3), .rsp_ready(rrdy), .rsp_data(rd3), .rsp_id(rid3),
        .busy(busy3), .mul_x(mx3), .mul_y(my3), .mul_p(mp3)
    );

    assign o_ready = sel ? ready3 : {1'b0, ready2};
    assign o_rv    = sel ? rv3    : rv2;
    assign o_busy  = sel ? busy3  : busy2;
    assign o_rd    = sel ? rd3    : rd2;
    assign o_id    = sel ? rid3   : {1'b0, rid2};
    assign o_mx    = sel ? mx3    : mx2;
    assign o_my    = sel ? my3    : my2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] prod(input logic [15:0] a, input logic [15:0] b);
        return 32'(a) * 32'(b);
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        v     = '0;
        rrdy  = 1'b1;
        #1;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // One transaction on requester id with rsp_ready held high; returns data, id, latency
    task automatic txn(input int id, input logic [15:0] a, input logic [15:0] b,
                       output logic [31:0] data, output int rid, output int lat);
        int n;
        ra[id*16 +: 16] = a;
        rb[id*16 +: 16] = b;
        v[id] = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (o_ready[id] === 1'b1 || n >= 20) break;
            n++;
        end
        chk("accept_timeout", 32'(n < 20), 32'd1);
        @(posedge clk); #1;
        v[id] = 1'b0;
        lat = 0;
        forever begin
            @(negedge clk);
            lat++;
            if (o_rv === 1'b1 || lat >= 20) break;
        end
        data = o_rd;
        rid  = int'(o_id);
        @(posedge clk); #1;
    endtask

    // Random traffic against a queue-based model of grants, products and fairness
    task automatic run_rand(input int n, input int ntx);
        logic [31:0] exp_d[$];
        int          exp_id[$];
        int          waits[3];
        int          served[3];
        int          got, issued, cyc, gi;
        logic [15:0] a, b;
        do_reset();
        got = 0; issued = 0; cyc = 0;
        for (int i = 0; i < 3; i++) begin waits[i] = 0; served[i] = 0; end
        while (got < ntx && cyc < ntx * 40) begin
            @(negedge clk);
            cyc++;
            gi = -1;
            for (int i = 0; i < n; i++) if (o_ready[i] === 1'b1) gi = i;
            if ($countones(o_ready) > 1) chk("ready_onehot", 32'($countones(o_ready)), 32'd1);
            if (gi >= 0) begin
                chk("grant_has_valid", 32'(v[gi]), 32'd1);
                exp_d.push_back(prod(ra[gi*16 +: 16], rb[gi*16 +: 16]));
                exp_id.push_back(gi);
                served[gi]++;
                waits[gi] = 0;
                for (int i = 0; i < n; i++) begin
                    if (i != gi && v[i]) begin
                        waits[i]++;
                        chk("starvation", 32'(waits[i] >= n), 32'd0);
                    end
                end
            end
            if (o_rv === 1'b1 && rrdy) begin
                if (exp_d.size() == 0) begin
                    chk("spurious_rsp", 32'd1, 32'd0);
                end else begin
                    chk("rand_data", o_rd, exp_d.pop_front());
                    chk("rand_id", 32'(o_id), 32'(exp_id.pop_front()));
                end
                got++;
            end
            @(posedge clk); #1;
            if (gi >= 0) v[gi] = 1'b0;
            for (int i = 0; i < n; i++) begin
                if (!v[i] && issued < ntx && $urandom_range(0, 2) == 0) begin
                    a = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
                    b = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
                    ra[i*16 +: 16] = a;
                    rb[i*16 +: 16] = b;
                    v[i] = 1'b1;
                    issued++;
                end
            end
            rrdy = ($urandom_range(0, 3) != 0);
        end
        chk("rand_all_done", 32'(got), 32'(ntx));
        for (int i = 0; i < n; i++) chk("rand_served", 32'(served[i] > 0), 32'd1);
        v = '0;
        rrdy = 1'b1;
    endtask

    initial begin
        logic [31:0] d, d0;
        int          rid, lat, n, gi, ng, nr, cyc;
        int          order[4];
        logic [31:0] eq_d[$];
        int          eq_id[$];
        logic [1:0]  id0;

        // Reset state
        sel = 1'b0; v = '0; ra = '0; rb = '0; rrdy = 1'b0; rst_n = 1'b0;
        #1;
        chk("rst_rsp_valid", 32'(o_rv), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_ready", 32'(o_ready), 32'd0);
        chk("rst_data", o_rd, 32'd0);
        chk("rst_mul_x", 32'(o_mx), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        rrdy = 1'b1;

        // Single transaction and latency
        txn(0, 16'h1234, 16'h5678, d, rid, lat);
        chk("t1_data", d, 32'h0626_0060);
        chk("t1_id", 32'(rid), 32'd0);
        chk("t1_latency", 32'(lat), 32'd5);

        // Arithmetic corners
        txn(0, 16'hFFFF, 16'hFFFF, d, rid, lat);
        chk("t2_max", d, 32'hFFFE_0001);
        txn(0, 16'h00FF, 16'h0100, d, rid, lat);
        chk("t2_ff_x_100", d, 32'h0000_FF00);
        txn(0, 16'h0000, 16'hBEEF, d, rid, lat);
        chk("t2_zero", d, 32'h0000_0000);
        txn(1, 16'hA5C3, 16'h3C5A, d, rid, lat);
        chk("t2_req1_data", d, prod(16'hA5C3, 16'h3C5A));
        chk("t2_req1_id", 32'(rid), 32'd1);

        // Contention: both requesters held valid for four grants
        do_reset();
        ra = {16'h0, 16'($urandom), 16'($urandom)};
        rb = {16'h0, 16'($urandom), 16'($urandom)};
        v  = 3'b011;
        ng = 0; nr = 0; cyc = 0;
        while (nr < 4 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            gi = -1;
            for (int i = 0; i < 2; i++) if (o_ready[i] === 1'b1) gi = i;
            if (gi >= 0 && ng < 4) begin
                order[ng] = gi;
                eq_d.push_back(prod(ra[gi*16 +: 16], rb[gi*16 +: 16]));
                eq_id.push_back(gi);
                ng++;
            end
            if (o_rv === 1'b1 && eq_d.size() > 0) begin
                chk("t3_data", o_rd, eq_d.pop_front());
                chk("t3_id", 32'(o_id), 32'(eq_id.pop_front()));
                nr++;
            end
            @(posedge clk); #1;
            if (gi >= 0) begin
                if (ng >= 4) v = '0;
                else begin
                    ra[gi*16 +: 16] = 16'($urandom);
                    rb[gi*16 +: 16] = 16'($urandom);
                end
            end
        end
        chk("t3_count", 32'(nr), 32'd4);
        for (int k = 0; k < 4; k++) chk("t3_order", 32'(order[k]), 32'(k % 2));

        // Back-pressure in DONE
        rrdy = 1'b0;
        ra[31:16] = 16'hC0DE; rb[31:16] = 16'h1F2E;
        v[1] = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (o_ready[1] === 1'b1 || n >= 20) break;
            n++;
        end
        chk("t4_accept", 32'(n < 20), 32'd1);
        @(posedge clk); #1;
        v[1] = 1'b0;
        ra[15:0] = 16'h1111; rb[15:0] = 16'h2222;
        v[0] = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (o_rv === 1'b1 || n >= 20) break;
            n++;
        end
        chk("t4_rsp_seen", 32'(n < 20), 32'd1);
        d0  = o_rd;
        id0 = o_id;
        chk("t4_data", d0, prod(16'hC0DE, 16'h1F2E));
        chk("t4_id", 32'(id0), 32'd1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("t4_hold_valid", 32'(o_rv), 32'd1);
            chk("t4_hold_data", o_rd, d0);
            chk("t4_hold_id", 32'(o_id), 32'(id0));
            chk("t4_ready_low", 32'(o_ready), 32'd0);
            chk("t4_busy", 32'(o_busy), 32'd1);
        end
        @(posedge clk); #1;
        rrdy = 1'b1;
        v[0] = 1'b0;
        @(negedge clk);
        chk("t4_valid_before_edge", 32'(o_rv), 32'd1);
        @(negedge clk);
        chk("t4_released", 32'(o_rv), 32'd0);
        chk("t4_idle", 32'(o_busy), 32'd0);

        // Reset in the middle of a transaction
        ra[15:0] = 16'h1234; rb[15:0] = 16'hABCD;
        v[0] = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (o_ready[0] === 1'b1 || n >= 20) break;
            n++;
        end
        chk("t5_accept", 32'(n < 20), 32'd1);
        @(posedge clk); #1;
        v[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("t5_p2_mul_x", 32'(o_mx), 32'h34);
        chk("t5_p2_mul_y", 32'(o_my), 32'hAB);
        chk("t5_p2_busy", 32'(o_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", 32'(o_rv), 32'd0);
        chk("t5_rst_busy", 32'(o_busy), 32'd0);
        chk("t5_rst_mul_x", 32'(o_mx), 32'd0);
        chk("t5_rst_mul_y", 32'(o_my), 32'd0);
        chk("t5_rst_data", o_rd, 32'd0);
        chk("t5_rst_id", 32'(o_id), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        v = 3'b011;
        #1;
        chk("t5_req0_first", 32'(o_ready), 32'd1);
        v = '0;

        // Randomized traffic on both configurations
        sel = 1'b0;
        run_rand(2, 500);
        sel = 1'b1;
        run_rand(3, 500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
